// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA / VRAM subsystem.
// FB_DEPTH is the number of framebuffer words. pixel_t is one RGB444 word.
package vga_pkg;

  localparam int unsigned ADDR_W      = 17;
  localparam int unsigned DATA_W      = 12;
  localparam int unsigned FB_W        = 320;
  localparam int unsigned FB_H        = 240;
  localparam int unsigned SCALE_SHIFT = 1;
  localparam int unsigned FB_DEPTH    = FB_W * FB_H;

  typedef logic [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   req_i[1:0]   per-requester request
//   en_i         grant enable; when low no grant is issued and the pointer holds
//   gnt_o[1:0]   one-hot (or zero) combinational grant
// The pointer names the requester that wins the next contested grant. It flips
// only when both requesters are present and a grant is actually issued.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;
  logic contested;

  assign contested = en_i & req_i[0] & req_i[1];

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (contested) begin
        gnt_o = ptr_q ? 2'b10 : 2'b01;
        ptr_d = ~ptr_q;
      end else begin
        gnt_o = req_i;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port VRAM between VGA scan-out and two writers.
// Ports:
//   clk, reset             clock and asynchronous active-high reset
//   i_pix_stb, active, x, y  timing generator inputs (one strobe per pixel)
//   pix_rgb, pix_valid     registered colour, valid pulses 3 clk after the strobe
//   ram_addr/we/wdata      registered VRAM command; ram_rdata returns 1 clk later
//   wr_req, wr_addr*, wr_data*  writer request inputs
//   wr_ack, wr_err         per-writer grant pulse and out-of-range pulse
// Scan reads always win the slot. An off-framebuffer pixel carries a black token
// down the same pipeline and leaves the slot to the writers.
module vram_arbiter #(
  parameter int unsigned ADDR_W      = vga_pkg::ADDR_W,
  parameter int unsigned DATA_W      = vga_pkg::DATA_W,
  parameter int unsigned FB_W        = vga_pkg::FB_W,
  parameter int unsigned FB_H        = vga_pkg::FB_H,
  parameter int unsigned SCALE_SHIFT = vga_pkg::SCALE_SHIFT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pix_stb,
  input  logic              active,
  input  logic [15:0]       x,
  input  logic [15:0]       y,
  output logic [DATA_W-1:0] pix_rgb,
  output logic              pix_valid,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [DATA_W-1:0] wr_data1,
  output logic [1:0]        wr_ack,
  output logic [1:0]        wr_err
);

  localparam int unsigned FbDepth = FB_W * FB_H;

  // Scan decision
  logic              scan_need, scan_in_range, scan_rd, scan_blk;
  logic [15:0]       fx, fy;
  logic [ADDR_W-1:0] scan_addr;

  assign scan_need     = i_pix_stb & active;
  assign fx            = x >> SCALE_SHIFT;
  assign fy            = y >> SCALE_SHIFT;
  assign scan_in_range = (32'(fx) < FB_W) && (32'(fy) < FB_H);
  assign scan_rd       = scan_need & scan_in_range;
  assign scan_blk      = scan_need & ~scan_in_range;
  assign scan_addr     = ADDR_W'(fy) * ADDR_W'(FB_W) + ADDR_W'(fx);

  // Writer arbitration (only in slots scan-out does not use)
  logic [1:0] gnt;
  logic [1:0] wr_in_range;

  assign wr_in_range[0] = 32'(wr_addr0) < FbDepth;
  assign wr_in_range[1] = 32'(wr_addr1) < FbDepth;

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .reset (reset),
    .req_i (wr_req),
    .en_i  (~scan_rd),
    .gnt_o (gnt)
  );

  // Output / pipeline registers
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [1:0]        wr_ack_q, wr_ack_d;
  logic [1:0]        wr_err_q, wr_err_d;
  logic              s1_vld_q, s1_vld_d, s1_blk_q, s1_blk_d;
  logic              s2_vld_q, s2_vld_d, s2_blk_q, s2_blk_d;
  logic [DATA_W-1:0] pix_rgb_q, pix_rgb_d;
  logic              pix_valid_q, pix_valid_d;

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    wr_ack_d    = gnt;
    wr_err_d    = gnt & ~wr_in_range;

    if (scan_rd) begin
      ram_addr_d = scan_addr;
    end else if (gnt[0]) begin
      ram_addr_d  = wr_addr0;
      ram_wdata_d = wr_data0;
      ram_we_d    = wr_in_range[0];
    end else if (gnt[1]) begin
      ram_addr_d  = wr_addr1;
      ram_wdata_d = wr_data1;
      ram_we_d    = wr_in_range[1];
    end

    // t+1: address on the RAM; t+2: data back; t+3: colour registered
    s1_vld_d    = scan_need;
    s1_blk_d    = scan_blk;
    s2_vld_d    = s1_vld_q;
    s2_blk_d    = s1_blk_q;
    pix_valid_d = s2_vld_q;
    pix_rgb_d   = pix_rgb_q;
    if (s2_vld_q) begin
      pix_rgb_d = s2_blk_q ? '0 : ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wr_ack_q    <= 2'b00;
      wr_err_q    <= 2'b00;
      s1_vld_q    <= 1'b0;
      s1_blk_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s2_blk_q    <= 1'b0;
      pix_rgb_q   <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      s1_vld_q    <= s1_vld_d;
      s1_blk_q    <= s1_blk_d;
      s2_vld_q    <= s2_vld_d;
      s2_blk_q    <= s2_blk_d;
      pix_rgb_q   <= pix_rgb_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign wr_ack    = wr_ack_q;
  assign wr_err    = wr_err_q;
  assign pix_rgb   = pix_rgb_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 1-cycle-latency VRAM.
module tb_vram_arbiter;
  import vga_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_pix_stb, active;
  logic [15:0]       x, y;
  logic [DATA_W-1:0] pix_rgb;
  logic              pix_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [1:0]        wr_req;
  logic [ADDR_W-1:0] wr_addr0, wr_addr1;
  logic [DATA_W-1:0] wr_data0, wr_data1;
  logic [1:0]        wr_ack, wr_err;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_t mem [FB_DEPTH];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  vram_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_pix_stb (i_pix_stb),
    .active    (active),
    .x         (x),
    .y         (y),
    .pix_rgb   (pix_rgb),
    .pix_valid (pix_valid),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .wr_req    (wr_req),
    .wr_addr0  (wr_addr0),
    .wr_data0  (wr_data0),
    .wr_addr1  (wr_addr1),
    .wr_data1  (wr_data1),
    .wr_ack    (wr_ack),
    .wr_err    (wr_err)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_pix_stb = 1'b0; active = 1'b0; x = '0; y = '0;
    wr_req = 2'b00; wr_addr0 = '0; wr_addr1 = '0; wr_data0 = '0; wr_data1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({pix_rgb, pix_valid, ram_addr, ram_we, ram_wdata, wr_ack, wr_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rgb=%h v=%b addr=%0d we=%b wd=%h ack=%b err=%b, want all 0",
               pix_rgb, pix_valid, ram_addr, ram_we, ram_wdata, wr_ack, wr_err);
    end
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if ({pix_rgb, pix_valid, ram_addr, ram_we, ram_wdata, wr_ack, wr_err} !== '0) begin
      n_fail++;
      $display("FAIL idle_outputs: got rgb=%h v=%b addr=%0d we=%b wd=%h ack=%b err=%b, want all 0",
               pix_rgb, pix_valid, ram_addr, ram_we, ram_wdata, wr_ack, wr_err);
    end
  endtask

  task automatic test_scan_read();
    do_reset();
    mem[643] = 12'hABC;
    x = 16'd7; y = 16'd5; active = 1'b1; i_pix_stb = 1'b1;
    tick();                                   // t+1
    i_pix_stb = 1'b0;
    n_checks++;
    if (ram_addr !== 17'd643 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_addr: got addr=%0d we=%b, want addr=643 we=0", ram_addr, ram_we);
    end
    tick();                                   // t+2
    n_checks++;
    if (pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL scan_early_valid: got pix_valid=%b at t+2, want 0", pix_valid);
    end
    tick();                                   // t+3
    n_checks++;
    if (pix_valid !== 1'b1 || pix_rgb !== 12'hABC) begin
      n_fail++;
      $display("FAIL scan_pixel: got v=%b rgb=%h, want v=1 rgb=abc", pix_valid, pix_rgb);
    end
    tick();                                   // t+4
    n_checks++;
    if (pix_valid !== 1'b0 || pix_rgb !== 12'hABC) begin
      n_fail++;
      $display("FAIL scan_pulse_end: got v=%b rgb=%h, want v=0 rgb=abc", pix_valid, pix_rgb);
    end
  endtask

  task automatic test_reset_mid_read();
    logic seen;
    do_reset();
    mem[643] = 12'hABC;
    x = 16'd7; y = 16'd5; active = 1'b1; i_pix_stb = 1'b1;
    tick();
    i_pix_stb = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ram_addr !== 17'd0 || pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_clear: got addr=%0d v=%b, want addr=0 v=0", ram_addr, pix_valid);
    end
    tick();
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (pix_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_flush: got pix_valid seen=%b after reset, want 0", seen);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_ack [12];
    exp_ack = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10,
                2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01};
    do_reset();
    mem[1000] = '0; mem[2000] = '0;
    wr_addr0 = 17'd1000; wr_data0 = 12'h111;
    wr_addr1 = 17'd2000; wr_data1 = 12'h222;
    wr_req = 2'b11;
    x = 16'd7; y = 16'd5; active = 1'b1;
    for (int c = 0; c < 12; c++) begin
      i_pix_stb = (c % 4 == 0);
      tick();
      n_checks++;
      if (wr_ack !== exp_ack[c]) begin
        n_fail++;
        $display("FAIL contention_ack[%0d]: got ack=%b, want %b", c, wr_ack, exp_ack[c]);
      end
      n_checks++;
      if (exp_ack[c] == 2'b00) begin
        if (ram_we !== 1'b0 || ram_addr !== 17'd643) begin
          n_fail++;
          $display("FAIL contention_scan[%0d]: got we=%b addr=%0d, want we=0 addr=643",
                   c, ram_we, ram_addr);
        end
      end else begin
        if (ram_we !== 1'b1 ||
            ram_addr !== ((exp_ack[c] == 2'b01) ? 17'd1000 : 17'd2000)) begin
          n_fail++;
          $display("FAIL contention_write[%0d]: got we=%b addr=%0d, want we=1 addr=%0d",
                   c, ram_we, ram_addr, (exp_ack[c] == 2'b01) ? 1000 : 2000);
        end
      end
    end
    wr_req = 2'b00; i_pix_stb = 1'b0;
    tick(); tick();
    n_checks++;
    if (mem[1000] !== 12'h111 || mem[2000] !== 12'h222) begin
      n_fail++;
      $display("FAIL contention_ram: got mem[1000]=%h mem[2000]=%h, want 111 222",
               mem[1000], mem[2000]);
    end
  endtask

  task automatic test_single();
    do_reset();
    wr_addr0 = 17'd10; wr_data0 = 12'h00A;
    wr_addr1 = 17'd20; wr_data1 = 12'h00B;
    wr_req = 2'b10;
    tick();
    n_checks++;
    if (wr_ack !== 2'b10) begin
      n_fail++;
      $display("FAIL single_w1: got ack=%b, want 10", wr_ack);
    end
    wr_req = 2'b11;
    tick();
    n_checks++;
    if (wr_ack !== 2'b01) begin
      n_fail++;
      $display("FAIL single_noflip: got ack=%b, want 01", wr_ack);
    end
    tick();
    n_checks++;
    if (wr_ack !== 2'b10) begin
      n_fail++;
      $display("FAIL single_flip: got ack=%b, want 10", wr_ack);
    end
    wr_req = 2'b00;
    tick();
  endtask

  task automatic test_oor_scan();
    do_reset();
    mem[643] = 12'hABC;
    x = 16'd7; y = 16'd5; active = 1'b1; i_pix_stb = 1'b1;
    tick();
    i_pix_stb = 1'b0;
    tick(); tick();
    n_checks++;
    if (pix_rgb !== 12'hABC) begin
      n_fail++;
      $display("FAIL oor_prefill: got rgb=%h, want abc", pix_rgb);
    end
    wr_addr1 = 17'd500; wr_data1 = 12'h333; wr_req = 2'b10;
    x = 16'd700; y = 16'd0; i_pix_stb = 1'b1;
    tick();                                   // t+1
    wr_req = 2'b00; i_pix_stb = 1'b0;
    n_checks++;
    if (wr_ack !== 2'b10 || wr_err !== 2'b00 || ram_we !== 1'b1 || ram_addr !== 17'd500) begin
      n_fail++;
      $display("FAIL oor_slot: got ack=%b err=%b we=%b addr=%0d, want ack=10 err=00 we=1 addr=500",
               wr_ack, wr_err, ram_we, ram_addr);
    end
    tick();                                   // t+2
    n_checks++;
    if (pix_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_early: got pix_valid=%b at t+2, want 0", pix_valid);
    end
    tick();                                   // t+3
    n_checks++;
    if (pix_valid !== 1'b1 || pix_rgb !== 12'h000) begin
      n_fail++;
      $display("FAIL oor_black: got v=%b rgb=%h, want v=1 rgb=000", pix_valid, pix_rgb);
    end
  endtask

  task automatic test_writer_err();
    do_reset();
    mem[100] = '0;
    wr_addr0 = 17'd76800; wr_data0 = 12'h555; wr_req = 2'b01;
    tick();
    n_checks++;
    if (wr_ack !== 2'b01 || wr_err !== 2'b01 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL werr_oor: got ack=%b err=%b we=%b, want ack=01 err=01 we=0",
               wr_ack, wr_err, ram_we);
    end
    wr_addr0 = 17'd100; wr_data0 = 12'h0F0;
    tick();
    wr_req = 2'b00;
    n_checks++;
    if (wr_ack !== 2'b01 || wr_err !== 2'b00 || ram_we !== 1'b1 ||
        ram_addr !== 17'd100 || ram_wdata !== 12'h0F0) begin
      n_fail++;
      $display("FAIL werr_ok: got ack=%b err=%b we=%b addr=%0d wd=%h, want 01 00 1 100 0f0",
               wr_ack, wr_err, ram_we, ram_addr, ram_wdata);
    end
    tick();
    n_checks++;
    if (wr_ack !== 2'b00 || ram_we !== 1'b0 || ram_addr !== 17'd100) begin
      n_fail++;
      $display("FAIL werr_idle: got ack=%b we=%b addr=%0d, want ack=00 we=0 addr=100",
               wr_ack, ram_we, ram_addr);
    end
    n_checks++;
    if (mem[100] !== 12'h0F0) begin
      n_fail++;
      $display("FAIL werr_ram: got mem[100]=%h, want 0f0", mem[100]);
    end
  endtask

  task automatic test_drop_on_scan();
    do_reset();
    mem[3000] = '0;
    wr_addr1 = 17'd3000; wr_data1 = 12'h777; wr_req = 2'b10;
    x = 16'd7; y = 16'd5; active = 1'b1; i_pix_stb = 1'b1;
    tick();
    wr_req = 2'b00; i_pix_stb = 1'b0;
    n_checks++;
    if (wr_ack !== 2'b00 || ram_we !== 1'b0 || ram_addr !== 17'd643) begin
      n_fail++;
      $display("FAIL drop_scan: got ack=%b we=%b addr=%0d, want ack=00 we=0 addr=643",
               wr_ack, ram_we, ram_addr);
    end
    tick();
    n_checks++;
    if (wr_ack !== 2'b00 || ram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_noack: got ack=%b we=%b, want ack=00 we=0", wr_ack, ram_we);
    end
    wr_addr0 = 17'd4000; wr_data0 = 12'h444; wr_req = 2'b11;
    tick();
    wr_req = 2'b00;
    n_checks++;
    if (wr_ack !== 2'b01) begin
      n_fail++;
      $display("FAIL drop_ptr: got ack=%b, want 01", wr_ack);
    end
    tick(); tick();
    n_checks++;
    if (mem[3000] !== 12'h000) begin
      n_fail++;
      $display("FAIL drop_ram: got mem[3000]=%h, want 000", mem[3000]);
    end
  endtask

  initial begin
    for (int i = 0; i < int'(FB_DEPTH); i++) mem[i] = '0;
    ram_rdata = '0;
    test_reset();
    test_scan_read();
    test_reset_mid_read();
    test_contention();
    test_single();
    test_oor_scan();
    test_writer_err();
    test_drop_on_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port video RAM (VRAM) between the VGA scan-out path and two game-logic writers.
- The scan-out path has absolute priority: each active pixel strobe gets one RAM read, which is then returned as a registered colour.
- Cycles not used by scan-out go to writers 0/1 under round-robin, using a request/acknowledge handshake.
- Sits between the VGA timing generator (x, y, active, pixel strobe) and the VRAM/colour output stage.

Parameters:
- ADDR_W, 17, VRAM address width.
- DATA_W, 12, pixel word width (RGB444).
- FB_W, 320, framebuffer width in pixels.
- FB_H, 240, framebuffer height in lines.
- SCALE_SHIFT, 1, screen-to-framebuffer down-scale (fb coordinate = screen coordinate >> SCALE_SHIFT).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_pix_stb  in  1  pixel strobe, one clk wide.
- active  in  1  timing generator active-video flag.
- x  in  16  screen column.
- y  in  16  screen row.
- pix_rgb  out  DATA_W  registered pixel colour.
- pix_valid  out  1  one-cycle pulse when pix_rgb updates.
- ram_addr  out  ADDR_W  registered VRAM address.
- ram_we  out  1  registered VRAM write enable.
- ram_wdata  out  DATA_W  registered VRAM write data.
- ram_rdata  in  DATA_W  VRAM read data, 1-cycle latency after ram_addr.
- wr_req  in  2  per-writer request.
- wr_addr0  in  ADDR_W  writer 0 address.
- wr_data0  in  DATA_W  writer 0 data.
- wr_addr1  in  ADDR_W  writer 1 address.
- wr_data1  in  DATA_W  writer 1 data.
- wr_ack  out  2  per-writer one-cycle grant pulse.
- wr_err  out  2  per-writer one-cycle out-of-range pulse.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous, active-high.
- Reset values: all outputs 0, round-robin pointer = writer 0, read pipeline flushed.
- Reset mid-operation:
  - In-flight reads are discarded and no pix_valid is produced for them.
  - Writers still holding wr_req are re-arbitrated after release.
- Per-cycle arbitration (cycle t):
  - scan_need = i_pix_stb & active.
  - fx = x >> SCALE_SHIFT, fy = y >> SCALE_SHIFT.
  - If scan_need and fx < FB_W and fy < FB_H: the slot is a scan read.
    - Address = fy*FB_W + fx, computed at ADDR_W width with no truncation for in-range values; shift-add or multiply is acceptable.
  - If scan_need but fx or fy is out of range: no RAM access; the pixel pipeline carries a forced-black token (0); the slot goes to the writers.
  - Otherwise the slot goes to the writers:
    - Only one writer requesting: it wins.
    - Both requesting: the pointer's writer wins, and the pointer then flips to the other writer.
    - The pointer changes only on a contested grant.
- Grant outputs at t+1:
  - ram_addr/ram_we/ram_wdata registered from the winner.
  - wr_ack[w] pulses one cycle.
- Writer handshake:
  - The writer holds wr_req, address and data stable until it sees wr_ack.
  - Dropping wr_req before ack is legal; no write occurs.
  - After ack, the writer may re-assert immediately; the earliest next grant is t+1.
- Out-of-range writer address (addr >= FB_W*FB_H):
  - The request is granted normally: wr_ack and wr_err pulse together at t+1.
  - ram_we stays 0 and the slot is consumed.
- Scan read pipeline:
  - t: decide. t+1: ram_addr. t+2: ram_rdata. t+3: pix_rgb registered and pix_valid pulses.
  - Fixed latency of 3 clk from i_pix_stb.
  - Forced-black tokens follow the same 3-cycle latency.
- When no scan access is pending and no writer is granted: ram_we = 0, and ram_addr holds its last value.
- Simultaneous scan + both writers: scan wins, no ack, pointer unchanged.
- Bandwidth: with stb every N ≥ 2 clk, writers get at least N−1 of N slots; with N = 1, writers proceed only during blanking.

Decomposition:
- Shared package vga_pkg holds:
  - constants FB_W, FB_H, SCALE_SHIFT, DATA_W, ADDR_W;
  - the FB_DEPTH = FB_W*FB_H localparam;
  - typedef pixel_t (DATA_W bits).
- Sub-module rr_arb2: a 2-requester round-robin with a pointer-update-on-contention input.
- Address computation and pipeline stay in the top module.

Test Plan:
- Reset, then idle inputs -> all outputs 0; assert reset mid-read -> no pix_valid emerges for the flushed read.
- x=7, y=5, active=1, stb pulse, RAM preloaded [2*320+3]=0xABC -> ram_addr=643 at t+1, ram_we=0; pix_rgb=0xABC, pix_valid=1 at t+3.
- Both writers request every cycle with stb period 4 and active=1 -> 3 of 4 slots granted, acks alternate 0,1,0,…; no ack on stb cycles; the pointer does not flip on stb cycles.
- x=700 (fx=350 ≥ 320), active=1, stb -> ram_we=0, RAM slot given to pending writer 1 (wr_ack[1]=1 at t+1); pix_rgb=0, pix_valid=1 at t+3.
- Writer 0 addr=76800 -> wr_ack[0]=wr_err[0]=1 at t+1, ram_we=0; then addr=100, data=0x0F0 -> ram_we=1, ram_addr=100, ram_wdata=0x0F0 at t+1.
- Writer 1 drops wr_req in the same cycle a stb scan wins -> no ack, no write; pointer and RAM unchanged.
